counter_mod_sync: RTL

//  Synchronous, fully parametrised multi-digit modulo counter for the dual-slope ADC.

---
 rtl/counter_pkg.sv | 16 +
 rtl/counter_digit.sv | 41 ++++
 rtl/counter_mod_sync.sv | 104 ++++++++++
 3 files changed

// File: rtl/counter_pkg.sv
// Shared helpers for the cascaded modulo counter: digit width, digit type, load clamp.
package counter_pkg;

  typedef logic [31:0] digit_t;

  function automatic int digit_w(input int radix);
    return $clog2(radix);
  endfunction

  // Out-of-range load digits saturate to the top legal value.
  function automatic digit_t clamp_digit(input digit_t v, input int radix);
    if (v > digit_t'(radix - 1)) return digit_t'(radix - 1);
    return v;
  endfunction

endpackage

// File: rtl/counter_digit.sv
// One modulo-RADIX digit; clr > load > inc/dec, carries come from the parent.
module counter_digit
  import counter_pkg::*;
#(
  parameter int RADIX = 10,
  parameter int DW    = 4
) (
  input  logic          clk,
  input  logic          rst_s,
  input  logic          clr,
  input  logic          load,
  input  logic [DW-1:0] ld_d,
  input  logic          inc,
  input  logic          dec,
  output logic [DW-1:0] d,
  output logic          at_max,
  output logic          at_zero
);

  localparam logic [DW-1:0] MAXV = DW'(RADIX - 1);

  logic [DW-1:0] d_q, d_d;

  always_comb begin
    d_d = d_q;
    if (clr)        d_d = '0;
    else if (load)  d_d = ld_d;
    else if (inc)   d_d = (d_q == MAXV) ? '0 : d_q + 1'b1;
    else if (dec)   d_d = (d_q == '0) ? MAXV : d_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst_s) d_q <= '0;
    else       d_q <= d_d;
  end

  assign d       = d_q;
  assign at_max  = (d_q == MAXV);
  assign at_zero = (d_q == '0);

endmodule

// File: rtl/counter_mod_sync.sv
// NDIGITS x modulo-RADIX counter with clear, load, capture, wrap pulse and sticky ovf.
// Optional macro CNT_UPDOWN_EN adds the dir port for down-counting.
module counter_mod_sync
  import counter_pkg::*;
#(
  parameter  int NDIGITS = 4,
  parameter  int RADIX   = 10,
  localparam int DW      = digit_w(RADIX)
) (
  input  logic                  clk,
  input  logic                  rst_s,
  input  logic                  enb,
  input  logic                  clr,
  input  logic                  load,
  input  logic [NDIGITS*DW-1:0] load_val,
  input  logic                  cap,
`ifdef CNT_UPDOWN_EN
  input  logic                  dir,
`endif
  output logic [NDIGITS*DW-1:0] q,
  output logic [NDIGITS*DW-1:0] q_cap,
  output logic                  cnt_max,
  output logic                  cnt_zero,
  output logic                  wrap,
  output logic                  ovf
);

  logic up_cnt, dn_cnt;
`ifdef CNT_UPDOWN_EN
  assign up_cnt = enb & ~dir;
  assign dn_cnt = enb & dir;
`else
  assign up_cnt = enb;
  assign dn_cnt = 1'b0;
`endif

  logic [NDIGITS-1:0] at_max, at_zero, inc, dec;
  logic [NDIGITS:0]   max_below, zero_below;

  // Ripple carry/borrow: a digit moves only when every lower digit is at its edge.
  always_comb begin
    max_below[0]  = 1'b1;
    zero_below[0] = 1'b1;
    inc           = '0;
    dec           = '0;
    for (int i = 0; i < NDIGITS; i++) begin
      inc[i]           = up_cnt & max_below[i];
      dec[i]           = dn_cnt & zero_below[i];
      max_below[i+1]   = max_below[i] & at_max[i];
      zero_below[i+1]  = zero_below[i] & at_zero[i];
    end
  end

  for (genvar g = 0; g < NDIGITS; g++) begin : g_digit
    logic [DW-1:0] ld_clamped;
    assign ld_clamped = DW'(clamp_digit(digit_t'(load_val[g*DW +: DW]), RADIX));

    counter_digit #(.RADIX(RADIX), .DW(DW)) u_digit (
      .clk    (clk),
      .rst_s  (rst_s),
      .clr    (clr),
      .load   (load),
      .ld_d   (ld_clamped),
      .inc    (inc[g]),
      .dec    (dec[g]),
      .d      (q[g*DW +: DW]),
      .at_max (at_max[g]),
      .at_zero(at_zero[g])
    );
  end

  assign cnt_max  = &at_max;
  assign cnt_zero = &at_zero;

  logic                  wrap_evt;
  logic                  wrap_q, wrap_d, ovf_q, ovf_d;
  logic [NDIGITS*DW-1:0] q_cap_q, q_cap_d;

  assign wrap_evt = ~clr & ~load &
                    ((up_cnt & max_below[NDIGITS]) | (dn_cnt & zero_below[NDIGITS]));

  always_comb begin
    wrap_d  = wrap_evt;
    ovf_d   = clr ? 1'b0 : (ovf_q | wrap_evt);
    q_cap_d = cap ? q : q_cap_q;
  end

  always_ff @(posedge clk) begin
    if (rst_s) begin
      wrap_q  <= 1'b0;
      ovf_q   <= 1'b0;
      q_cap_q <= '0;
    end else begin
      wrap_q  <= wrap_d;
      ovf_q   <= ovf_d;
      q_cap_q <= q_cap_d;
    end
  end

  assign wrap  = wrap_q;
  assign ovf   = ovf_q;
  assign q_cap = q_cap_q;

endmodule
